fast_bconv_stream: RTL



---
 rtl/fast_bconv_stream.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fast_bconv_stream.sv
// Streaming RNS fast base conversion: residues in the input basis -> residues in the target basis.
// Optional input range check is compiled in with `define FAST_BCONV_RANGE_CHECK_EN.
module fast_bconv_stream #(
  parameter int RNS_PRIME_BITS = 8,
  parameter int IN_BASIS_LEN   = 3,
  parameter int OUT_BASIS_LEN  = 2,
  parameter int LANES          = 1,
  parameter logic [RNS_PRIME_BITS-1:0] IN_BASIS [IN_BASIS_LEN] = '{8'd3, 8'd5, 8'd7},
  parameter logic [RNS_PRIME_BITS-1:0] OUT_BASIS [OUT_BASIS_LEN] = '{8'd11, 8'd13},
  parameter logic [RNS_PRIME_BITS-1:0] ZiLUT [IN_BASIS_LEN] = '{8'd2, 8'd1, 8'd1},
  parameter logic [RNS_PRIME_BITS-1:0] YMODB [OUT_BASIS_LEN][IN_BASIS_LEN] =
    '{'{8'd2, 8'd10, 8'd4}, '{8'd9, 8'd8, 8'd2}}
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [IN_BASIS_LEN-1:0][RNS_PRIME_BITS-1:0]   input_RNSint,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [OUT_BASIS_LEN-1:0][RNS_PRIME_BITS-1:0]  output_RNSint,
  output logic                                          out_err
);
  localparam int W      = RNS_PRIME_BITS;
  localparam int NSTEPS = (IN_BASIS_LEN + LANES - 1) / LANES;
  localparam int SW     = $clog2(NSTEPS + 1);

  typedef logic [W-1:0]   rns_residue_t;
  typedef logic [2*W-1:0] wide_rns_residue_t;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t       state, state_next;
  logic [SW-1:0] step;
  rns_residue_t a_q      [IN_BASIS_LEN];
  rns_residue_t acc      [OUT_BASIS_LEN];
  rns_residue_t acc_next [OUT_BASIS_LEN];
  logic         accept, finalize;

  function automatic rns_residue_t mul_mod(rns_residue_t x, rns_residue_t y, rns_residue_t m);
    wide_rns_residue_t p;
    p = wide_rns_residue_t'(x) * wide_rns_residue_t'(y);
    return rns_residue_t'(p % wide_rns_residue_t'(m));
  endfunction

  function automatic rns_residue_t add_mod(rns_residue_t x, rns_residue_t y, rns_residue_t m);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[W-1:0];
  endfunction

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  // One extra ACCUM cycle (step == NSTEPS) moves the finished sums into the output register.
  assign finalize  = (state == ACCUM) && (step == SW'(NSTEPS));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACCUM;
      ACCUM:   if (finalize) state_next = DONE;
      DONE:    if (out_ready) state_next = accept ? ACCUM : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Each lane picks its operand for the current step from a constant-indexed mux.
  always_comb begin
    rns_residue_t sel_a, sel_y;
    sel_a = '0;
    sel_y = '0;
    for (int j = 0; j < OUT_BASIS_LEN; j++) begin
      acc_next[j] = acc[j];
      for (int l = 0; l < LANES; l++) begin
        sel_a = '0;
        sel_y = '0;
        for (int s = 0; s < NSTEPS; s++) begin
          if (s * LANES + l < IN_BASIS_LEN) begin
            if (step == SW'(s)) begin
              sel_a = a_q[s * LANES + l];
              sel_y = YMODB[j][s * LANES + l];
            end
          end
        end
        acc_next[j] = add_mod(acc_next[j], mul_mod(sel_a, sel_y, OUT_BASIS[j]), OUT_BASIS[j]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step <= '0;
      for (int i = 0; i < IN_BASIS_LEN; i++) a_q[i] <= '0;
      for (int j = 0; j < OUT_BASIS_LEN; j++) begin
        acc[j]           <= '0;
        output_RNSint[j] <= '0;
      end
    end else if (accept) begin
      step <= '0;
      for (int i = 0; i < IN_BASIS_LEN; i++)
        a_q[i] <= mul_mod(input_RNSint[i], ZiLUT[i], IN_BASIS[i]);
      for (int j = 0; j < OUT_BASIS_LEN; j++) acc[j] <= '0;
    end else if (state == ACCUM) begin
      if (finalize) begin
        for (int j = 0; j < OUT_BASIS_LEN; j++) output_RNSint[j] <= acc[j];
      end else begin
        step <= step + SW'(1);
        for (int j = 0; j < OUT_BASIS_LEN; j++) acc[j] <= acc_next[j];
      end
    end
  end

`ifdef FAST_BCONV_RANGE_CHECK_EN
  logic err_in, err_q;

  always_comb begin
    err_in = 1'b0;
    for (int i = 0; i < IN_BASIS_LEN; i++)
      if (input_RNSint[i] >= IN_BASIS[i]) err_in = 1'b1;
  end

  // Flag travels with its operand: captured at accept, published with the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q   <= 1'b0;
      out_err <= 1'b0;
    end else begin
      if (accept)   err_q   <= err_in;
      if (finalize) out_err <= err_q;
    end
  end
`else
  assign out_err = 1'b0;
`endif

endmodule
